// File: rtl/parking_pkg.sv
// Shared types for the parking-gate front end: FSM state encoding and sensor polarity.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENT_A,
    ENT_AB,
    ENT_B,
    EXT_B,
    EXT_AB,
    EXT_A
  } gate_state_t;

  localparam logic SENSOR_BLOCKED = 1'b1;

endpackage

// File: rtl/sensor_debouncer.sv
// Brings one raw photo-beam into the clk domain and accepts a new level only after
// it has been stable for DB_CYCLES consecutive cycles.
module sensor_debouncer #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronized level agrees with db restarts the stability window.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_MAX) db_d = sync2_q;
      else                  cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so the synchronizer stages shift, not collapse.
      sync1_q <= raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db = db_q;

endmodule

// File: rtl/car_direction_detector.sv
// Classifies car passes through the two-beam gate; emits one-cycle enter/exit pulses
// on a completed pass and seq_err on an impossible beam transition.
module car_direction_detector
  import parking_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_a,
  input  logic sensor_b,
  output logic enter,
  output logic exit,
  output logic seq_err,
  output logic busy
);

  logic        a_db, b_db;
  logic [1:0]  ab;
  gate_state_t state_q, state_next;
  logic        enter_q, enter_d;
  logic        exit_q, exit_d;
  logic        err_q, err_d;
  logic        busy_q;

  sensor_debouncer #(.DB_CYCLES(DB_CYCLES)) u_deb_a (
    .clk  (clk),
    .reset(reset),
    .raw  (sensor_a),
    .db   (a_db)
  );

  sensor_debouncer #(.DB_CYCLES(DB_CYCLES)) u_deb_b (
    .clk  (clk),
    .reset(reset),
    .raw  (sensor_b),
    .db   (b_db)
  );

  assign ab = {a_db == SENSOR_BLOCKED, b_db == SENSOR_BLOCKED};

  always_comb begin
    state_next = state_q;
    enter_d    = 1'b0;
    exit_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if      (ab == 2'b10) state_next = ENT_A;
        else if (ab == 2'b01) state_next = EXT_B;
      end
      ENT_A: begin
        if      (ab == 2'b11) state_next = ENT_AB;
        else if (ab == 2'b00) state_next = IDLE;
        else if (ab == 2'b01) begin state_next = IDLE; err_d = 1'b1; end
      end
      ENT_AB: begin
        if      (ab == 2'b01) state_next = ENT_B;
        else if (ab == 2'b10) state_next = ENT_A;
        else if (ab == 2'b00) begin state_next = IDLE; err_d = 1'b1; end
      end
      ENT_B: begin
        if      (ab == 2'b00) begin state_next = IDLE; enter_d = 1'b1; end
        else if (ab == 2'b11) state_next = ENT_AB;
        else if (ab == 2'b10) begin state_next = IDLE; err_d = 1'b1; end
      end
      EXT_B: begin
        if      (ab == 2'b11) state_next = EXT_AB;
        else if (ab == 2'b00) state_next = IDLE;
        else if (ab == 2'b10) begin state_next = IDLE; err_d = 1'b1; end
      end
      EXT_AB: begin
        if      (ab == 2'b10) state_next = EXT_A;
        else if (ab == 2'b01) state_next = EXT_B;
        else if (ab == 2'b00) begin state_next = IDLE; err_d = 1'b1; end
      end
      EXT_A: begin
        if      (ab == 2'b00) begin state_next = IDLE; exit_d = 1'b1; end
        else if (ab == 2'b11) state_next = EXT_AB;
        else if (ab == 2'b01) begin state_next = IDLE; err_d = 1'b1; end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pulses and busy are registered together with the state, so all move on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_next;
      enter_q <= enter_d;
      exit_q  <= exit_d;
      err_q   <= err_d;
      busy_q  <= (state_next != IDLE);
    end
  end

  assign enter   = enter_q;
  assign exit    = exit_q;
  assign seq_err = err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_car_direction_detector.sv
// Bench for car_direction_detector: table-driven pass scenarios, hand-written corner
// sequences, and random beam activity checked every cycle against a pass-level model.
module tb_car_direction_detector;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sensor_a = 1'b0;
  logic sensor_b = 1'b0;
  logic enter, exit, seq_err, busy;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  car_direction_detector #(.DB_CYCLES(DB)) dut (
    .clk     (clk),
    .reset   (reset),
    .sensor_a(sensor_a),
    .sensor_b(sensor_b),
    .enter   (enter),
    .exit    (exit),
    .seq_err (seq_err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A pass is a walk along a fixed beam sequence; one step forward advances, one step
  // back retreats, anything else is an illegal jump.
  logic [1:0] ent_seq[5] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] ext_seq[5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};

  bit   m_s1[2], m_s2[2], m_db[2];
  bit   m_hist[2][DB];
  int   m_fill[2];
  int   m_dir, m_idx;
  bit   m_enter, m_exit, m_err, m_busy;
  logic [1:0] m_ab, m_cur, m_fwd, m_bwd;
  bit   m_raw[2];
  bit   all_flip;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_dir = 0; m_idx = 0;
      m_enter = 0; m_exit = 0; m_err = 0; m_busy = 0;
      for (int s = 0; s < 2; s++) begin
        m_s1[s] = 0; m_s2[s] = 0; m_db[s] = 0; m_fill[s] = 0;
      end
    end else begin
      m_ab = {m_db[0], m_db[1]};
      m_enter = 0; m_exit = 0; m_err = 0;
      if (m_dir == 0) begin
        if (m_ab == 2'b10) begin m_dir = 1; m_idx = 1; end
        else if (m_ab == 2'b01) begin m_dir = 2; m_idx = 1; end
      end else begin
        m_cur = (m_dir == 1) ? ent_seq[m_idx]     : ext_seq[m_idx];
        m_fwd = (m_dir == 1) ? ent_seq[m_idx + 1] : ext_seq[m_idx + 1];
        m_bwd = (m_dir == 1) ? ent_seq[m_idx - 1] : ext_seq[m_idx - 1];
        if (m_ab == m_cur) begin
        end else if (m_ab == m_fwd) begin
          m_idx++;
          if (m_idx == 4) begin
            if (m_dir == 1) m_enter = 1; else m_exit = 1;
            m_dir = 0;
          end
        end else if (m_ab == m_bwd) begin
          m_idx--;
          if (m_idx == 0) m_dir = 0;
        end else begin
          m_err = 1;
          m_dir = 0;
        end
      end
      m_busy = (m_dir != 0);
      m_raw[0] = sensor_a;
      m_raw[1] = sensor_b;
      for (int s = 0; s < 2; s++) begin
        for (int k = DB - 1; k > 0; k--) m_hist[s][k] = m_hist[s][k-1];
        m_hist[s][0] = m_s2[s];
        if (m_fill[s] < DB) m_fill[s]++;
        all_flip = 1;
        for (int k = 0; k < DB; k++) if (m_hist[s][k] == m_db[s]) all_flip = 0;
        if (m_fill[s] == DB && all_flip) begin
          m_db[s] = !m_db[s];
          m_fill[s] = 0;
        end
        m_s2[s] = m_s1[s];
        m_s1[s] = m_raw[s];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_enter", int'(enter),   int'(m_enter));
      check("model_exit",  int'(exit),    int'(m_exit));
      check("model_err",   int'(seq_err), int'(m_err));
      check("model_busy",  int'(busy),    int'(m_busy));
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic a;
    logic b;
    int   hold;
    int   n_enter;
    int   n_exit;
    int   n_err;
    logic busy_end;
  } row_t;

  row_t rows[$];

  task automatic apply_row(input row_t r, input string tag);
    int ce = 0, cx = 0, cr = 0;
    sensor_a = r.a;
    sensor_b = r.b;
    for (int i = 0; i < r.hold; i++) begin
      @(negedge clk);
      ce += int'(enter);
      cx += int'(exit);
      cr += int'(seq_err);
    end
    check({tag, "_enter"}, ce, r.n_enter);
    check({tag, "_exit"},  cx, r.n_exit);
    check({tag, "_err"},   cr, r.n_err);
    check({tag, "_busy"},  int'(busy), int'(r.busy_end));
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2 reset = 1'b1;
    @(negedge clk); #2 reset = 1'b0;
    @(negedge clk);
  endtask

  int first_at;
  int cnt_e;
  logic [1:0] cur_ab;

  initial begin
    rows.push_back('{1'b0, 1'b0, 10, 0, 0, 0, 1'b0});
    // entry
    rows.push_back('{1'b1, 1'b0, 10, 0, 0, 0, 1'b1});
    rows.push_back('{1'b1, 1'b1, 10, 0, 0, 0, 1'b1});
    rows.push_back('{1'b0, 1'b1, 10, 0, 0, 0, 1'b1});
    rows.push_back('{1'b0, 1'b0, 10, 1, 0, 0, 1'b0});
    // two back-to-back exits
    for (int i = 0; i < 2; i++) begin
      rows.push_back('{1'b0, 1'b1, 10, 0, 0, 0, 1'b1});
      rows.push_back('{1'b1, 1'b1, 10, 0, 0, 0, 1'b1});
      rows.push_back('{1'b1, 1'b0, 10, 0, 0, 0, 1'b1});
      rows.push_back('{1'b0, 1'b0, 10, 0, 1, 0, 1'b0});
    end
    // back-out after reaching ab
    rows.push_back('{1'b1, 1'b0, 10, 0, 0, 0, 1'b1});
    rows.push_back('{1'b1, 1'b1, 10, 0, 0, 0, 1'b1});
    rows.push_back('{1'b1, 1'b0, 10, 0, 0, 0, 1'b1});
    rows.push_back('{1'b0, 1'b0, 10, 0, 0, 0, 1'b0});
    // back-out after reaching b
    rows.push_back('{1'b1, 1'b0, 10, 0, 0, 0, 1'b1});
    rows.push_back('{1'b1, 1'b1, 10, 0, 0, 0, 1'b1});
    rows.push_back('{1'b0, 1'b1, 10, 0, 0, 0, 1'b1});
    rows.push_back('{1'b1, 1'b1, 10, 0, 0, 0, 1'b1});
    rows.push_back('{1'b1, 1'b0, 10, 0, 0, 0, 1'b1});
    rows.push_back('{1'b0, 1'b0, 10, 0, 0, 0, 1'b0});
    // illegal jump ENT_A -> 01; IDLE then picks 01 up as the start of an exit
    rows.push_back('{1'b1, 1'b0, 10, 0, 0, 0, 1'b1});
    rows.push_back('{1'b0, 1'b1, 10, 0, 0, 1, 1'b1});
    rows.push_back('{1'b0, 1'b0, 10, 0, 0, 0, 1'b0});

    // reset held with both beams blocked
    @(negedge clk); #2 reset = 1'b1; sensor_a = 1'b1; sensor_b = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_enter", int'(enter),   0);
    check("rst_exit",  int'(exit),    0);
    check("rst_err",   int'(seq_err), 0);
    check("rst_busy",  int'(busy),    0);
    #2 reset = 1'b0;
    @(negedge clk);
    apply_row('{1'b1, 1'b1, 12, 0, 0, 0, 1'b0}, "post_rst_11");
    apply_row('{1'b0, 1'b0, 12, 0, 0, 0, 1'b0}, "post_rst_00");

    for (int i = 0; i < rows.size(); i++)
      apply_row(rows[i], $sformatf("row%0d", i));

    // exact latency from final raw release to enter pulse
    apply_row('{1'b1, 1'b0, 10, 0, 0, 0, 1'b1}, "lat_a");
    apply_row('{1'b1, 1'b1, 10, 0, 0, 0, 1'b1}, "lat_ab");
    apply_row('{1'b0, 1'b1, 10, 0, 0, 0, 1'b1}, "lat_b");
    sensor_b = 1'b0;
    first_at = -1;
    cnt_e = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (enter) begin
        cnt_e++;
        if (first_at < 0) first_at = i;
      end
    end
    check("lat_cycles", first_at, DB + 3);
    check("lat_count",  cnt_e, 1);
    check("lat_busy",   int'(busy), 0);

    // 2-cycle glitch on sensor_a while idle
    sensor_a = 1'b1;
    repeat (2) @(negedge clk);
    sensor_a = 1'b0;
    begin
      int cb = 0, cp = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        cb += int'(busy);
        cp += int'(enter) + int'(exit) + int'(seq_err);
      end
      check("glitch_busy",   cb, 0);
      check("glitch_pulses", cp, 0);
    end

    // reset while in ENT_B discards the pass
    apply_row('{1'b1, 1'b0, 10, 0, 0, 0, 1'b1}, "rb_a");
    apply_row('{1'b1, 1'b1, 10, 0, 0, 0, 1'b1}, "rb_ab");
    apply_row('{1'b0, 1'b1, 10, 0, 0, 0, 1'b1}, "rb_b");
    @(negedge clk); #2 reset = 1'b1;
    @(negedge clk);
    check("rb_busy_in_rst", int'(busy), 0);
    sensor_a = 1'b0; sensor_b = 1'b0;
    #2 reset = 1'b0;
    @(negedge clk);
    apply_row('{1'b0, 1'b0, 15, 0, 0, 0, 1'b0}, "rb_release");

    // random beam activity, mostly single-beam steps so real passes happen often
    cur_ab = 2'b00;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) cur_ab = 2'($urandom_range(0, 3));
      else if ($urandom_range(0, 1) == 0) cur_ab[0] = ~cur_ab[0];
      else cur_ab[1] = ~cur_ab[1];
      sensor_a = cur_ab[1];
      sensor_b = cur_ab[0];
      repeat ($urandom_range(1, 12)) @(negedge clk);
      if (i == 150) pulse_reset();
    end
    sensor_a = 1'b0; sensor_b = 1'b0;
    repeat (20) @(negedge clk);
    check("final_busy", int'(busy), 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
